gaussian_window_gen: RTL and testbench
======================================

Name: gaussian_window_gen

Overview:
- Upstream feeder for gaussian_core.
- Accepts a raster-order stream of 8-bit pixels, one per handshake.
- Uses WIDTH-1 line buffers plus a WIDTH x WIDTH register window to emit every fully-interior 7x7 neighbourhood as one MASKLEN-bit word, in the packing gaussian_core consumes.
- Replaces pre-built window words in dram_ori; driven by a pixel source, drives gaussian_core input_pixels.

Parameters:
- BITS, 8, pixel width.
- WIDTH, 7, kernel/window edge.
- MASKLEN, 392, window word width; must equal BITS*WIDTH*WIDTH.
- IMG_W, 512, image columns.
- IMG_H, 512, image rows.
- CBITS, 10, row/column counter width; must satisfy 2^CBITS > max(IMG_W, IMG_H).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  in_pixel is valid.
- in_pixel  input  BITS  raster pixel.
- in_ready  output  1  block can accept a pixel this cycle.
- out_valid  output  1  window holds a valid neighbourhood.
- out_ready  input  1  consumer accepts the window.
- window  output  MASKLEN  packed 7x7 neighbourhood.
- out_row  output  CBITS  image row of the window centre.
- out_col  output  CBITS  image column of the window centre.
- frame_done  output  1  one-cycle pulse after the final window of a frame is consumed.

Behaviour:
- Reset (rst=1 at posedge):
  - out_valid=0, frame_done=0; row/col counters=0; out_row/out_col=0; window=0.
  - in_ready=1 after reset.
  - Line-buffer contents are not cleared; priming discards stale data.
- Accept: a pixel is accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (combinational).
  - in_valid gaps are allowed; no state advances without an accept.
- On accept at (row, col):
  - Window shifts one column toward c=0.
  - New column c=WIDTH-1 is {lb[0][col] .. lb[5][col], in_pixel}, with lb[0] the oldest row.
  - Line buffers cascade at address col: lb[k] <= lb[k+1] for k<5, lb[5] <= in_pixel.
  - col increments; at IMG_W-1 it wraps to 0 and row increments.
- Packing: window[(r*WIDTH+c)*BITS +: BITS] = pixel(row-6+r, col-6+c).
  - r=0 is the top/oldest row; c=0 is the leftmost/oldest column.
- Emission:
  - If the accepted pixel has row>=WIDTH-1 and col>=WIDTH-1, then on the next cycle out_valid=1, out_row=row-3, out_col=col-3.
  - Latency: accept to out_valid is 1 cycle.
  - Windows spanning a row wrap (col<6) are never emitted.
  - Windows per frame: (IMG_H-6)*(IMG_W-6).
- out_valid clears on out_valid && out_ready, unless a new emitting pixel is accepted the same cycle.
  - Simultaneous consume and accept: out_valid stays 1 with the new window.
- Backpressure: while out_valid && !out_ready, window/out_row/out_col hold stable and in_ready=0.
- Frame end:
  - After pixel (IMG_H-1, IMG_W-1) is accepted, the counters return to (0,0).
  - frame_done pulses 1 cycle in the cycle after that last window is consumed.
  - Pixels of the next frame may be accepted in that same cycle; priming restarts at row 0.
- Reset mid-frame: abandons the frame; any pending window is dropped; no frame_done.
- Line buffers: 6 x IMG_W x BITS; register array or inferred RAM.
  - Read-before-write at the same address within one accept.

Test Plan:
- Use IMG_W=IMG_H=8 unless noted; pixel(r,c) = r*8+c; out_ready=1; in_valid=1 continuously.
  - -> first out_valid 1 cycle after accepting pixel 54; window byte0=0, byte6=6, byte48=54; out_row=3, out_col=3.
  - -> exactly 4 windows, centres (3,3),(3,4),(4,3),(4,4); last window byte48=63.
  - -> frame_done pulses once.
- Same stream with out_ready low for 5 cycles after the first window -> window/out_row/out_col stable, in_ready=0 for those 5 cycles, no pixel lost; remaining 3 windows match the model.
- Random in_valid gaps (~50% duty), random out_ready -> window sequence identical to the continuous run; count=4 per frame.
- Two back-to-back frames, frame 2 pixel = (r*8+c)^0xFF -> frame 2 windows contain no frame 1 data; e.g. first window byte0=0xFF; 2 frame_done pulses.
- rst asserted at pixel 40 of frame 1, then a full frame -> out_valid=0 and counters=0 the cycle after reset; exactly 4 windows from the new frame; 1 frame_done.
- IMG_W=16, IMG_H=9 -> 30 windows; centres cover rows 3..5, cols 3..12; no emission at col<6 of any row.

Source files
------------

// File: rtl/gaussian_window_gen.sv
// Streaming 7x7 neighbourhood generator feeding gaussian_core: raster pixels in,
// fully-interior windows out, built from WIDTH-1 line buffers plus a register window.
module gaussian_window_gen #(
  parameter int BITS    = 8,
  parameter int WIDTH   = 7,
  parameter int MASKLEN = 392,
  parameter int IMG_W   = 512,
  parameter int IMG_H   = 512,
  parameter int CBITS   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [BITS-1:0]    in_pixel,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MASKLEN-1:0] window,
  output logic [CBITS-1:0]   out_row,
  output logic [CBITS-1:0]   out_col,
  output logic               frame_done
);

  localparam int LB_ROWS = WIDTH - 1;
  localparam int HALF    = (WIDTH - 1) / 2;
  localparam int AW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  localparam logic [CBITS-1:0] EDGE_C   = CBITS'(WIDTH - 1);
  localparam logic [CBITS-1:0] HALF_C   = CBITS'(HALF);
  localparam logic [CBITS-1:0] COL_LAST = CBITS'(IMG_W - 1);
  localparam logic [CBITS-1:0] ROW_LAST = CBITS'(IMG_H - 1);
  localparam logic [CBITS-1:0] ONE_C    = CBITS'(1'b1);

  logic [BITS-1:0]    lb_r [LB_ROWS][IMG_W];
  logic [CBITS-1:0]   row_r;
  logic [CBITS-1:0]   col_r;
  logic [MASKLEN-1:0] win_r;
  logic               last_pend_r;

  logic [AW-1:0]      col_idx_s;
  logic [BITS-1:0]    col_in_s [WIDTH];
  logic [MASKLEN-1:0] win_next_s;
  logic               accept_s;
  logic               consume_s;
  logic               emit_s;
  logic               at_last_s;

  assign in_ready  = !out_valid || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign consume_s = out_valid && out_ready;
  assign emit_s    = accept_s && (row_r >= EDGE_C) && (col_r >= EDGE_C);
  assign at_last_s = (row_r == ROW_LAST) && (col_r == COL_LAST);
  assign col_idx_s = col_r[AW-1:0];
  assign window    = win_r;

  // Incoming column: line-buffer taps at the current column (oldest row first), then the new pixel.
  always_comb begin
    for (int k = 0; k < LB_ROWS; k++) begin
      col_in_s[k] = lb_r[k][col_idx_s];
    end
    col_in_s[WIDTH-1] = in_pixel;
  end

  // Shift every window row one column toward c=0 and load the incoming column at c=WIDTH-1.
  always_comb begin
    win_next_s = win_r;
    for (int r = 0; r < WIDTH; r++) begin
      for (int c = 0; c < WIDTH - 1; c++) begin
        win_next_s[(r*WIDTH+c)*BITS +: BITS] = win_r[(r*WIDTH+c+1)*BITS +: BITS];
      end
      win_next_s[(r*WIDTH+WIDTH-1)*BITS +: BITS] = col_in_s[r];
    end
  end

  // Line-buffer cascade; the taps above are read before this write lands.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int k = 0; k < LB_ROWS - 1; k++) begin
        lb_r[k][col_idx_s] <= col_in_s[k+1];
      end
      lb_r[LB_ROWS-1][col_idx_s] <= in_pixel;
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_r <= {CBITS{1'b0}};
      col_r <= {CBITS{1'b0}};
    end else if (accept_s) begin
      if (col_r == COL_LAST) begin
        col_r <= {CBITS{1'b0}};
        if (row_r == ROW_LAST) begin
          row_r <= {CBITS{1'b0}};
        end else begin
          row_r <= row_r + ONE_C;
        end
      end else begin
        col_r <= col_r + ONE_C;
      end
    end
  end

  // Window register and output handshake; the window only moves on an accept, which
  // cannot happen while a window is held under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_r       <= {MASKLEN{1'b0}};
      out_valid   <= 1'b0;
      out_row     <= {CBITS{1'b0}};
      out_col     <= {CBITS{1'b0}};
      last_pend_r <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= consume_s && last_pend_r;
      if (accept_s) begin
        win_r <= win_next_s;
      end
      if (emit_s) begin
        out_valid   <= 1'b1;
        out_row     <= row_r - HALF_C;
        out_col     <= col_r - HALF_C;
        last_pend_r <= at_last_s;
      end else if (consume_s) begin
        out_valid   <= 1'b0;
        last_pend_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gaussian_window_gen.sv
// Self-checking bench for gaussian_window_gen: scoreboarded 8x8 frames driven from a
// scenario table, plus stall, back-to-back, mid-frame reset and a 16x9 geometry.
module tb_gaussian_window_gen;

  localparam int BITS = 8;
  localparam int ML   = 392;
  localparam int CB   = 10;
  localparam int W    = 8;
  localparam int H    = 8;
  localparam int BW   = 16;
  localparam int BH   = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_ready, out_valid, frame_done;
  logic          out_ready = 1'b1;
  logic [7:0]    in_pixel;
  logic [ML-1:0] window;
  logic [CB-1:0] out_row, out_col;

  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_frame_done;
  logic [7:0]    b_in_pixel;
  logic [ML-1:0] b_window;
  logic [CB-1:0] b_out_row, b_out_col;

  gaussian_window_gen #(.BITS(BITS), .WIDTH(7), .MASKLEN(ML), .IMG_W(W), .IMG_H(H), .CBITS(CB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .window(window), .out_row(out_row),
    .out_col(out_col), .frame_done(frame_done));

  gaussian_window_gen #(.BITS(BITS), .WIDTH(7), .MASKLEN(ML), .IMG_W(BW), .IMG_H(BH), .CBITS(CB)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_pixel(b_in_pixel), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .window(b_window), .out_row(b_out_row),
    .out_col(b_out_col), .frame_done(b_frame_done));

  typedef struct {
    logic [ML-1:0] win;
    logic [CB-1:0] row;
    logic [CB-1:0] col;
    logic          last;
  } exp_t;

  typedef struct {
    logic [7:0] pix_xor;
    int         valid_pct;
    int         ready_pct;
    int         exp_win;
    logic [7:0] exp_b0;
    logic [7:0] exp_b6;
    logic [7:0] exp_b48;
    logic [7:0] exp_last_b48;
  } vec_t;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  exp_t bq[$];
  logic [ML-1:0] got_win[$];
  logic [CB-1:0] got_row[$];
  logic [CB-1:0] got_col[$];
  int n_fd = 0;
  int n_bwin = 0;
  int n_bfd = 0;

  int   ready_pct = 100;
  logic stall_arm = 1'b0;
  int   stall_left = 0;
  logic stall_used = 1'b0;

  // Consumer model: random out_ready, plus a single 5-cycle stall on the first window when armed.
  always begin
    @(posedge clk);
    #1;
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else if (stall_arm && !stall_used && out_valid) begin
      stall_used = 1'b1;
      stall_left = 4;
      out_ready  = 1'b0;
    end else begin
      out_ready = ($urandom_range(99) < ready_pct);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [ML-1:0] act, input logic [ML-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [ML-1:0] b_win(input int cr, input int cc);
    logic [ML-1:0] w;
    w = {ML{1'b0}};
    for (int r = 0; r < 7; r++) begin
      for (int c = 0; c < 7; c++) begin
        w[(r*7+c)*8 +: 8] = 8'((cr - 3 + r) * BW + (cc - 3 + c));
      end
    end
    return w;
  endfunction

  // Reference model and scoreboard for both instances, evaluated mid-cycle.
  task automatic monitor();
    logic [7:0] img [H][W];
    int   mr = 0, mc = 0, br = 0, bc = 0;
    logic mv = 1'b0, mfd = 1'b0;
    logic cons, acc, nv, nfd;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mr = 0; mc = 0; mv = 1'b0; mfd = 1'b0; br = 0; bc = 0;
        exp_q.delete();
        bq.delete();
      end else begin
        chki("out_valid", int'(out_valid), int'(mv));
        chki("frame_done", int'(frame_done), int'(mfd));
        chki("in_ready", int'(in_ready), int'(!mv || out_ready));
        if (frame_done) n_fd++;
        cons = mv && out_ready;
        acc  = in_valid && (!mv || out_ready);
        nv   = mv;
        nfd  = 1'b0;
        if (cons) begin
          if (exp_q.size() == 0) begin
            chki("spurious_window", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("window", window, e.win);
            chki("out_row", int'(out_row), int'(e.row));
            chki("out_col", int'(out_col), int'(e.col));
            nfd = e.last;
          end
          got_win.push_back(window);
          got_row.push_back(out_row);
          got_col.push_back(out_col);
          nv = 1'b0;
        end
        if (acc) begin
          img[mr][mc] = in_pixel;
          if (mr >= 6 && mc >= 6) begin
            e.win = {ML{1'b0}};
            for (int r = 0; r < 7; r++) begin
              for (int c = 0; c < 7; c++) begin
                e.win[(r*7+c)*8 +: 8] = img[mr-6+r][mc-6+c];
              end
            end
            e.row  = CB'(mr - 3);
            e.col  = CB'(mc - 3);
            e.last = (mr == H - 1) && (mc == W - 1);
            exp_q.push_back(e);
            nv = 1'b1;
          end
          if (mc == W - 1) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
          end else begin
            mc++;
          end
        end
        mv  = nv;
        mfd = nfd;

        if (b_frame_done) n_bfd++;
        if (b_out_valid && b_out_ready) begin
          n_bwin++;
          if (bq.size() == 0) begin
            chki("b_spurious_window", 1, 0);
          end else begin
            e = bq.pop_front();
            chki("b_out_row", int'(b_out_row), int'(e.row));
            chki("b_out_col", int'(b_out_col), int'(e.col));
            chk("b_window", b_window, e.win);
          end
        end
        if (b_in_valid && b_in_ready) begin
          if (br >= 6 && bc >= 6) begin
            e.row  = CB'(br - 3);
            e.col  = CB'(bc - 3);
            e.win  = b_win(br - 3, bc - 3);
            e.last = 1'b0;
            bq.push_back(e);
          end
          if (bc == BW - 1) begin
            bc = 0;
            br = (br == BH - 1) ? 0 : br + 1;
          end else begin
            bc++;
          end
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the pixel has been accepted.
  task automatic drive_px(input logic [7:0] v, input int vpct);
    logic took;
    int   guard;
    while ($urandom_range(99) >= vpct) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_pixel = v;
    guard    = 0;
    forever begin
      #2;
      took = in_ready;
      @(posedge clk);
      #1;
      if (took) break;
      guard++;
      if (guard > 500) begin
        chki("accept_timeout", 1, 0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] x, input int vpct, input int n);
    for (int k = 0; k < n; k++) begin
      drive_px(8'(k) ^ x, vpct);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (g < 300) begin
      @(negedge clk);
      if (!out_valid && exp_q.size() == 0) break;
      g++;
    end
    if (g >= 300) chki("drain_timeout", 1, 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic stall_check();
    logic [ML-1:0] snap;
    int g;
    g = 0;
    while (!out_valid && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) begin
      chki("stall_wait_timeout", 1, 0);
    end else begin
      snap = window;
      chki("stall_first_b48", int'(snap[48*8 +: 8]), 54);
      chki("stall_first_row", int'(out_row), 3);
      chki("stall_first_col", int'(out_col), 3);
      for (int i = 0; i < 5; i++) begin
        if (i > 0) begin
          @(negedge clk);
          chk("stall_window_hold", window, snap);
          chki("stall_row_hold", int'(out_row), 3);
          chki("stall_col_hold", int'(out_col), 3);
        end
        chki("stall_in_ready", int'(in_ready), 0);
        chki("stall_out_valid", int'(out_valid), 1);
      end
    end
  endtask

  initial begin
    vec_t vt [4];
    int   w0, f0;
    logic [ML-1:0] fw, lw;

    vt[0] = '{8'h00, 100, 100, 4, 8'h00, 8'h06, 8'h36, 8'h3F};
    vt[1] = '{8'h00,  50,  50, 4, 8'h00, 8'h06, 8'h36, 8'h3F};
    vt[2] = '{8'hFF, 100, 100, 4, 8'hFF, 8'hF9, 8'hC9, 8'hC0};
    vt[3] = '{8'hA5,  40,  70, 4, 8'hA5, 8'hA3, 8'h93, 8'h9A};

    rst = 1'b1; in_valid = 1'b0; in_pixel = 8'h00;
    b_in_valid = 1'b0; b_in_pixel = 8'h00; b_out_ready = 1'b1;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chki("rst_out_valid", int'(out_valid), 0);
    chki("rst_frame_done", int'(frame_done), 0);
    chk("rst_window", window, {ML{1'b0}});
    chki("rst_out_row", int'(out_row), 0);
    chki("rst_out_col", int'(out_col), 0);
    chki("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      ready_pct = vt[i].ready_pct;
      w0 = got_win.size();
      f0 = n_fd;
      drive_frame(vt[i].pix_xor, vt[i].valid_pct, W * H);
      drain();
      chki("vec_win_count", got_win.size() - w0, vt[i].exp_win);
      chki("vec_frame_done_count", n_fd - f0, 1);
      if (got_win.size() >= w0 + 4) begin
        fw = got_win[w0];
        lw = got_win[w0 + 3];
        chki("vec_first_b0", int'(fw[7:0]), int'(vt[i].exp_b0));
        chki("vec_first_b6", int'(fw[55:48]), int'(vt[i].exp_b6));
        chki("vec_first_b48", int'(fw[391:384]), int'(vt[i].exp_b48));
        chki("vec_last_b48", int'(lw[391:384]), int'(vt[i].exp_last_b48));
        chki("vec_first_row", int'(got_row[w0]), 3);
        chki("vec_first_col", int'(got_col[w0]), 3);
        chki("vec_second_col", int'(got_col[w0 + 1]), 4);
        chki("vec_third_row", int'(got_row[w0 + 2]), 4);
        chki("vec_last_row", int'(got_row[w0 + 3]), 4);
        chki("vec_last_col", int'(got_col[w0 + 3]), 4);
      end
    end

    ready_pct = 100;
    stall_arm = 1'b1;
    w0 = got_win.size();
    f0 = n_fd;
    fork
      drive_frame(8'h00, 100, W * H);
      stall_check();
    join
    stall_arm = 1'b0;
    drain();
    chki("stall_win_count", got_win.size() - w0, 4);
    chki("stall_frame_done_count", n_fd - f0, 1);

    w0 = got_win.size();
    f0 = n_fd;
    drive_frame(8'h00, 100, W * H);
    drive_frame(8'hFF, 100, W * H);
    drain();
    chki("b2b_win_count", got_win.size() - w0, 8);
    chki("b2b_frame_done_count", n_fd - f0, 2);
    if (got_win.size() >= w0 + 5) begin
      fw = got_win[w0 + 4];
      chki("b2b_f2_first_b0", int'(fw[7:0]), 8'hFF);
      chki("b2b_f2_first_b48", int'(fw[391:384]), 8'hC9);
    end

    drive_frame(8'h00, 100, 40);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chki("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_window", window, {ML{1'b0}});
    chki("midrst_out_row", int'(out_row), 0);
    chki("midrst_out_col", int'(out_col), 0);
    chki("midrst_frame_done", int'(frame_done), 0);
    @(posedge clk);
    #1;
    w0 = got_win.size();
    f0 = n_fd;
    drive_frame(8'h00, 100, W * H);
    drain();
    chki("midrst_win_count", got_win.size() - w0, 4);
    chki("midrst_frame_done_count", n_fd - f0, 1);
    if (got_win.size() >= w0 + 1) begin
      fw = got_win[w0];
      chki("midrst_first_b0", int'(fw[7:0]), 0);
      chki("midrst_first_row", int'(got_row[w0]), 3);
    end

    for (int k = 0; k < BW * BH; k++) begin
      b_in_valid = 1'b1;
      b_in_pixel = 8'(k);
      #2;
      chki("b_in_ready", int'(b_in_ready), 1);
      @(posedge clk);
      #1;
    end
    b_in_valid = 1'b0;
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      if (!b_out_valid && bq.size() == 0) break;
    end
    repeat (3) @(negedge clk);
    chki("b_win_count", n_bwin, (BH - 6) * (BW - 6));
    chki("b_frame_done_count", n_bfd, 1);
    chki("b_queue_empty", bq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
